// File: rtl/apb_req_arbiter_if.sv
// Requester fabric and apb_master command/response bundle.
// master: arbiter side; slave: requesters, apb_master and slave side.
interface apb_req_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int PSEL_WIDTH = 2
);
  logic [NUM_REQ-1:0]            req_i;
  logic [NUM_REQ-1:0]            req_write_i;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_i;
  logic [NUM_REQ*PSEL_WIDTH-1:0] req_sel_i;
  logic [NUM_REQ-1:0]            gnt_o;
  logic [NUM_REQ-1:0]            done_o;
  logic [DATA_WIDTH-1:0]         rdata_o;
  logic                          err_o;
  logic                          busy_o;
  logic [1:0]                    M_PMODE_o;
  logic [ADDR_WIDTH-1:0]         M_PADDR_o;
  logic [PSEL_WIDTH-1:0]         M_PSEL_o;
  logic [DATA_WIDTH-1:0]         M_PWDATA_o;
  logic                          M_PENABLE_i;
  logic                          M_PREADY_i;
  logic [DATA_WIDTH-1:0]         M_PRDATA_i;
  logic                          M_PSLVERR_i;

  modport master (
    input  req_i, req_write_i, req_addr_i,
    input  req_wdata_i, req_sel_i,
    input  M_PENABLE_i, M_PREADY_i,
    input  M_PRDATA_i, M_PSLVERR_i,
    output gnt_o, done_o, rdata_o, err_o,
    output busy_o, M_PMODE_o, M_PADDR_o,
    output M_PSEL_o, M_PWDATA_o
  );

  modport slave (
    output req_i, req_write_i, req_addr_i,
    output req_wdata_i, req_sel_i,
    output M_PENABLE_i, M_PREADY_i,
    output M_PRDATA_i, M_PSLVERR_i,
    input  gnt_o, done_o, rdata_o, err_o,
    input  busy_o, M_PMODE_o, M_PADDR_o,
    input  M_PSEL_o, M_PWDATA_o
  );
endinterface

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one apb_master among NUM_REQ requesters.
// Ports: PCLK_i, PRESET_i (async active-low), bus (apb_req_arbiter_if.master).
module apb_req_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int PSEL_WIDTH = 2
) (
  input  logic                PCLK_i,
  input  logic                PRESET_i,
  apb_req_arbiter_if.master   bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam logic [IW:0] NR = (IW+1)'(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT, DONE
  } state_t;

  state_t state_q, state_d;

  logic [IW-1:0]         rr_q;
  logic [IW-1:0]         own_q;
  logic [IW-1:0]         win;
  logic [IW:0]           cand;
  logic                  any;
  logic                  wr_q;
  logic                  err_q;
  logic                  xfer_end;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [PSEL_WIDTH-1:0] sel_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [NUM_REQ-1:0]    gnt_d;
  logic [NUM_REQ-1:0]    done_d;
  logic [1:0]            pmode_d;

  logic [ADDR_WIDTH-1:0] addr_a  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_a [NUM_REQ];
  logic [PSEL_WIDTH-1:0] sel_a   [NUM_REQ];

  assign xfer_end = bus.M_PENABLE_i
                  & bus.M_PREADY_i;
  assign any      = |bus.req_i;

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      addr_a[k]  = bus.req_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
      wdata_a[k] = bus.req_wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
      sel_a[k]   = bus.req_sel_i[k*PSEL_WIDTH +: PSEL_WIDTH];
    end
  end

  // Walk offsets from farthest to nearest so the nearest
  // requester after rr_q is the one left in win.
  always_comb begin
    win  = rr_q;
    cand = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = {1'b0, rr_q} + (IW+1)'(i);
      if (cand >= NR)
        cand = cand - NR;
      if (bus.req_i[cand[IW-1:0]])
        win = cand[IW-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = '0;
    done_d  = '0;
    pmode_d = 2'b00;
    unique case (state_q)
      IDLE: begin
        if (any) begin
          gnt_d[win] = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        pmode_d = {1'b1, wr_q};
        state_d = WAIT;
      end
      WAIT: begin
        // Drop to NOP on the completing cycle so the
        // master returns to IDLE instead of chaining.
        if (xfer_end) begin
          state_d = DONE;
        end else begin
          pmode_d = {1'b1, wr_q};
        end
      end
      DONE: begin
        done_d[own_q] = 1'b1;
        state_d       = IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK_i or negedge PRESET_i) begin
    if (!PRESET_i) begin
      state_q <= IDLE;
      rr_q    <= IW'(NUM_REQ-1);
      own_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && any) begin
        own_q   <= win;
        rr_q    <= win;
        wr_q    <= bus.req_write_i[win];
        addr_q  <= addr_a[win];
        wdata_q <= wdata_a[win];
        sel_q   <= sel_a[win];
      end
      if (state_q == WAIT && xfer_end) begin
        if (!wr_q)
          rdata_q <= bus.M_PRDATA_i;
        err_q <= bus.M_PSLVERR_i;
      end
    end
  end

  // Grant is combinational from req_i; hold it low
  // while reset is asserted.
  assign bus.gnt_o      = gnt_d & {NUM_REQ{PRESET_i}};
  assign bus.done_o     = done_d;
  assign bus.busy_o     = (state_q != IDLE);
  assign bus.M_PMODE_o  = pmode_d;
  assign bus.M_PADDR_o  = addr_q;
  assign bus.M_PSEL_o   = sel_q;
  assign bus.M_PWDATA_o = wdata_q;
  assign bus.rdata_o    = rdata_q;
  assign bus.err_o      = err_q;
endmodule
